// File: rtl/whitening_pkg.sv
// Shared constants and state encoding for the whitening pipeline stages.
package whitening_pkg;
  localparam int DW     = 16;
  localparam int CH     = 4;
  localparam int NS     = 128;
  localparam int LOG2NS = 7;
  localparam int ACC_W  = DW + LOG2NS;

  localparam logic [LOG2NS-1:0] PTR_LAST = LOG2NS'(NS - 1);

  typedef enum logic [2:0] {
    CEN_IDLE  = 3'd0,
    CEN_ACCUM = 3'd1,
    CEN_MEAN  = 3'd2,
    CEN_OUT   = 3'd3,
    CEN_DONE  = 3'd4
  } cen_state_t;
endpackage

// File: rtl/cen_sample_buf.sv
// Sample store for one block: synchronous write, registered read (1-cycle latency).
module cen_sample_buf
  import whitening_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_wr_en,
  input  logic [LOG2NS-1:0]   i_wr_addr,
  input  logic [CH*DW-1:0]    i_wr_data,
  input  logic                i_rd_en,
  input  logic [LOG2NS-1:0]   i_rd_addr,
  output logic [CH*DW-1:0]    o_rd_data
);
  logic [CH*DW-1:0] r_mem [NS];
  logic [CH*DW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/centering_unit.sv
// Centering stage: buffers a block, computes per-channel means, streams centered samples.
// Define CEN_SAT_EN to saturate the centered difference instead of wrapping it.
module centering_unit
  import whitening_pkg::*;
(
  input  logic               CLK_cen,
  input  logic               RST_cen,
  input  logic               GO_cen,
  input  logic               En_mem1,
  input  logic [CH*DW-1:0]   Data_in,
  input  logic               GO_cov,
  output logic [CH*DW-1:0]   Cen_data,
  output logic               Cen_valid,
  output logic               Cen_last,
  output logic [CH*DW-1:0]   Mean_out,
  output logic               CEN_busy
);
  cen_state_t        r_state;
  logic [LOG2NS-1:0] r_wr_ptr;
  logic [LOG2NS-1:0] r_rd_ptr;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [CH*DW-1:0]  w_rd_data;

  // Sample 0 may arrive in the same cycle GO_cen rises, while still in IDLE.
  assign w_wr_en = En_mem1 && GO_cen && (r_state == CEN_IDLE || r_state == CEN_ACCUM);
  assign w_rd_en = GO_cov && GO_cen && (r_state == CEN_OUT);

  cen_sample_buf u_buf (
    .i_clk     (CLK_cen),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (Data_in),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge CLK_cen) begin
    if (RST_cen || !GO_cen) begin
      r_state  <= CEN_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= w_rd_en;
      r_last  <= w_rd_en && (r_rd_ptr == PTR_LAST);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      case (r_state)
        CEN_IDLE: begin
          r_state <= CEN_ACCUM;
          r_busy  <= 1'b1;
        end
        CEN_ACCUM: if (En_mem1 && r_wr_ptr == PTR_LAST) r_state <= CEN_MEAN;
        CEN_MEAN:  r_state <= CEN_OUT;
        CEN_OUT: begin
          if (GO_cov) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_rd_ptr == PTR_LAST) begin
              r_state <= CEN_DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        CEN_DONE: r_state <= CEN_DONE;
        default:  r_state <= CEN_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [ACC_W-1:0] r_sum;
      logic [DW-1:0]           r_mean;
      logic [DW-1:0]           w_in;
      logic [DW-1:0]           w_smp;
      logic [DW-1:0]           w_out;

      assign w_in  = Data_in[gi*DW +: DW];
      assign w_smp = w_rd_data[gi*DW +: DW];

      // Upper DW bits of the sum equal sum >>> LOG2NS truncated to DW (floor division).
      always_ff @(posedge CLK_cen) begin
        if (RST_cen) begin
          r_sum  <= '0;
          r_mean <= '0;
        end else if (!GO_cen) begin
          r_sum <= '0;
        end else if (r_state == CEN_MEAN) begin
          r_mean <= r_sum[ACC_W-1 -: DW];
          r_sum  <= '0;
        end else if (w_wr_en) begin
          r_sum <= r_sum + {{LOG2NS{w_in[DW-1]}}, w_in};
        end
      end

`ifdef CEN_SAT_EN
      logic [DW:0] w_diff;
      assign w_diff = {w_smp[DW-1], w_smp} - {r_mean[DW-1], r_mean};
      assign w_out  = (w_diff[DW] == w_diff[DW-1]) ? w_diff[DW-1:0]
                                                   : {w_diff[DW], {(DW-1){~w_diff[DW]}}};
`else
      assign w_out = w_smp - r_mean;
`endif

      assign Cen_data[gi*DW +: DW] = r_valid ? w_out : '0;
      assign Mean_out[gi*DW +: DW] = r_mean;
    end
  endgenerate

  assign Cen_valid = r_valid;
  assign Cen_last  = r_last;
  assign CEN_busy  = r_busy;
endmodule

// File: tb/tb_centering_unit.sv
// Self-checking bench for centering_unit: table-driven blocks, random blocks, abort and reset sequences.
module tb_centering_unit;
  import whitening_pkg::*;

  logic             clk = 1'b0;
  logic             rst_cen, go_cen, en_mem1, go_cov;
  logic [CH*DW-1:0] data_in;
  logic [CH*DW-1:0] cen_data, mean_out;
  logic             cen_valid, cen_last, cen_busy;

  always #5 clk = ~clk;

  centering_unit dut (
    .CLK_cen   (clk),
    .RST_cen   (rst_cen),
    .GO_cen    (go_cen),
    .En_mem1   (en_mem1),
    .Data_in   (data_in),
    .GO_cov    (go_cov),
    .Cen_data  (cen_data),
    .Cen_valid (cen_valid),
    .Cen_last  (cen_last),
    .Mean_out  (mean_out),
    .CEN_busy  (cen_busy)
  );

  typedef struct {
    int mode;   // 0 const100, 1 ramp ch0, 2 single -129, 3 alternating extremes, 4 random, 5 const5
    bit gap;
    bit bp;
    bit hand;
    int mean0;
    int first0;
    int last0;
  } vec_t;

`ifdef CEN_SAT_EN
  localparam int SAT_FIRST = 32767;
`else
  localparam int SAT_FIRST = -32768;
`endif

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] smp [NS][CH];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int lane(input logic [CH*DW-1:0] v, input int k);
    logic signed [DW-1:0] t;
    t = v[k*DW +: DW];
    return int'(t);
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int reduce(input int d);
    int lim;
    int r;
    lim = 1 << (DW - 1);
`ifdef CEN_SAT_EN
    if (d > lim - 1) r = lim - 1;
    else if (d < -lim) r = -lim;
    else r = d;
`else
    r = d % (2 * lim);
    if (r < 0) r = r + 2 * lim;
    if (r >= lim) r = r - 2 * lim;
`endif
    return r;
  endfunction

  task automatic fill(input int mode);
    for (int n = 0; n < NS; n++) begin
      for (int k = 0; k < CH; k++) begin
        case (mode)
          0: smp[n][k] = DW'(100);
          1: smp[n][k] = (k == 0) ? DW'(n) : DW'(0);
          2: smp[n][k] = (k == 0 && n == 0) ? DW'(-129) : DW'(0);
          3: smp[n][k] = (n % 2 == 0) ? DW'(32767) : DW'(-32768);
          4: smp[n][k] = DW'($urandom);
          default: smp[n][k] = DW'(5);
        endcase
      end
    end
  endtask

  task automatic write_samples(input int count, input bit gap);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < count && cyc < 4 * NS) begin
      en_mem1 = !(gap && (cyc % 2 == 1));
      if (en_mem1)
        for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = smp[idx][k];
      tick;
      if (en_mem1) idx++;
      cyc++;
    end
    en_mem1 = 1'b0;
    chk("write_count", idx, count);
  endtask

  task automatic run_block(input vec_t v, input int id);
    int means [CH];
    int got;
    int issued;
    int cyc;
    bit go;
    fill(v.mode);
    go_cen = 1'b1;
    write_samples(NS, v.gap);
    chk($sformatf("b%0d_busy_mean", id), int'(cen_busy), 1);
    tick;
    for (int k = 0; k < CH; k++) begin
      int s;
      s = 0;
      for (int n = 0; n < NS; n++) s += int'(smp[n][k]);
      means[k] = floor_div(s, NS);
      chk($sformatf("b%0d_mean_ch%0d", id, k), lane(mean_out, k), means[k]);
    end
    if (v.hand) chk($sformatf("b%0d_mean_hand", id), lane(mean_out, 0), v.mean0);
    got = 0;
    issued = 0;
    cyc = 0;
    while (got < NS && cyc < 4 * NS) begin
      go = (issued < NS) && (!v.bp || (cyc % 2 == 0));
      go_cov = go;
      tick;
      cyc++;
      if (go) issued++;
      chk($sformatf("b%0d_valid_lag", id), int'(cen_valid), int'(go));
      if (cen_valid) begin
        for (int k = 0; k < CH; k++)
          chk($sformatf("b%0d_out%0d_ch%0d", id, got, k), lane(cen_data, k),
              reduce(int'(smp[got][k]) - means[k]));
        if (v.hand && got == 0)      chk($sformatf("b%0d_first_hand", id), lane(cen_data, 0), v.first0);
        if (v.hand && got == NS - 1) chk($sformatf("b%0d_last_hand", id), lane(cen_data, 0), v.last0);
        chk($sformatf("b%0d_last_flag%0d", id, got), int'(cen_last), int'(got == NS - 1));
        got++;
      end else begin
        chk($sformatf("b%0d_last_idle", id), int'(cen_last), 0);
      end
    end
    go_cov = 1'b0;
    chk($sformatf("b%0d_out_count", id), got, NS);
    tick;
    tick;
    chk($sformatf("b%0d_busy_done", id), int'(cen_busy), 0);
    chk($sformatf("b%0d_valid_done", id), int'(cen_valid), 0);
    chk($sformatf("b%0d_mean_held", id), lane(mean_out, 0), means[0]);
    go_cen = 1'b0;
    tick;
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v5;
    tbl[0] = '{0, 1'b0, 1'b0, 1'b1, 100, 0, 0};
    tbl[1] = '{1, 1'b0, 1'b0, 1'b1, 63, -63, 64};
    tbl[2] = '{2, 1'b0, 1'b0, 1'b1, -2, -127, 2};
    tbl[3] = '{0, 1'b1, 1'b1, 1'b1, 100, 0, 0};
    tbl[4] = '{3, 1'b0, 1'b0, 1'b1, -1, SAT_FIRST, -32767};
    for (int i = 5; i < 8; i++)
      tbl[i] = '{4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 0};

    rst_cen = 1'b1;
    go_cen  = 1'b1;
    en_mem1 = 1'b1;
    go_cov  = 1'b1;
    data_in = '0;
    tick;
    tick;
    chk("rst_busy", int'(cen_busy), 0);
    chk("rst_valid", int'(cen_valid), 0);
    chk("rst_last", int'(cen_last), 0);
    chk("rst_data", int'(cen_data != '0), 0);
    chk("rst_mean", int'(mean_out != '0), 0);
    go_cen  = 1'b0;
    en_mem1 = 1'b0;
    go_cov  = 1'b0;
    rst_cen = 1'b0;
    tick;

    for (int i = 0; i < 8; i++) run_block(tbl[i], i);

    // Abort mid-accumulation, then restart and make sure nothing from the aborted run leaks in.
    fill(0);
    go_cen = 1'b1;
    write_samples(50, 1'b0);
    chk("abort_busy_before", int'(cen_busy), 1);
    go_cen = 1'b0;
    tick;
    chk("abort_busy", int'(cen_busy), 0);
    chk("abort_valid", int'(cen_valid), 0);
    v5 = '{5, 1'b0, 1'b0, 1'b1, 5, 0, 0};
    run_block(v5, 100);

    // Reset in the middle of the output stream.
    fill(1);
    go_cen = 1'b1;
    write_samples(NS, 1'b0);
    tick;
    go_cov = 1'b1;
    repeat (10) tick;
    chk("midout_valid", int'(cen_valid), 1);
    chk("midout_mean", lane(mean_out, 0), 63);
    rst_cen = 1'b1;
    tick;
    chk("midrst_valid", int'(cen_valid), 0);
    chk("midrst_data", int'(cen_data != '0), 0);
    chk("midrst_last", int'(cen_last), 0);
    chk("midrst_mean", int'(mean_out != '0), 0);
    chk("midrst_busy", int'(cen_busy), 0);
    rst_cen = 1'b0;
    go_cov  = 1'b0;
    go_cen  = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
